pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Parametrised hazard and redirect controller for the in-order RISC-V pipeline, generalising the fixed five-stage hazard unit to configurable depth and memory-stage position. It arbitrates load-use stalls, memory-busy stalls and redirects from branches, jumps, CSR writes, ifence, exceptions, returns and interrupts. It emits per-stage stall/flush vectors plus the fetch redirect target. A small FSM defers redirects while a data access is in flight and sequences ifence cache-flush completion.

## Interface
- NUM_STAGES, 5, pipeline depth; stage 0 = fetch
- ID_STAGE, 1, decode stage index; EX = ID_STAGE+1
- MEM_STAGE, 3, stage resolving branches/traps; ID_STAGE+1 < MEM_STAGE < NUM_STAGES
- CNT_W, 32, perf counter width
- Ports:
- CLK  in  1  clock
- RST  in  1  synchronous, active-high reset
- i_mem_busy, d_mem_busy  in  1  memory busy
- dren, dwen  in  1  MEM-stage data read/write request
- load_ex  in  1  EX instruction is a load
- rd_ex, rs1_id, rs2_id  in  5  register indices
- mispredict, jump  in  1  MEM-stage control-flow redirect
- brj_addr  in  32  branch/jump target
- csr_flush_req  in  1;  csr_pc  in  32
- ifence  in  1;  ifence_pc  in  32
- dflushed, iflushed  in  1  cache flush done
- exception, ret, intr  in  1  trap / xRET / pending interrupt
- priv_pc  in  32  trap or return target from priv block
- halt  in  1  halt instruction in MEM
- pc_en  out  1  fetch PC advance
- stall  out  NUM_STAGES  per-stage hold
- flush  out  NUM_STAGES  per-stage bubble
- npc_sel  out  1  take redirect_pc
- redirect_pc  out  32
- iren, dmem_access  out  1
- intr_taken  out  1  one-cycle acceptance pulse
- stall_cnt, flush_cnt  out  CNT_W  (macro only)

## Operation
- FSM: RUN, WAIT_MEM, IFENCE_WAIT, HALTED.
- Redirect priority (RUN): intr > exception > ret > mispredict|jump > csr_flush_req > ifence. Target: priv_pc, priv_pc, priv_pc, brj_addr, csr_pc, ifence_pc.
- Flush mask: stages 0..MEM_STAGE-1; intr/exception also flush MEM_STAGE.
- Redirect with d_mem_busy=1: latch source+target, go WAIT_MEM; all stages stalled; on d_mem_busy=0 issue latched redirect, return RUN. Later requests ignored while WAIT_MEM except intr, which overrides a latched non-trap source.
- ifence: flush mask applied, enter IFENCE_WAIT, stall 0..MEM_STAGE, pc_en=0 until dflushed&&iflushed, then npc_sel=1 to ifence_pc, return RUN.
- Load-use: load_ex && rd_ex!=0 && (rd_ex==rs1_id || rd_ex==rs2_id) → stall 0..ID_STAGE, flush EX, pc_en=0.
- dmem_access = dren|dwen. d_mem_busy&&dmem_access → stall 0..MEM_STAGE, flush MEM_STAGE+1 (if present).
- i_mem_busy → stall 0..ID_STAGE-1, flush ID_STAGE unless a downstream stall holds ID.
- Redirect overrides load-use and i_mem_busy stalls in same cycle.
- halt (no higher redirect) → HALTED: pc_en=0, iren=0, stall all; left only by RST.
- iren = 1 except HALTED, IFENCE_WAIT, reset.

## Timing
- Outputs combinational from inputs and state; state and latches registered on CLK.
- RUN redirect: npc_sel, redirect_pc, flush same cycle; fetch at target next cycle.
- WAIT_MEM exit: redirect in first cycle d_mem_busy=0.
- intr_taken: one cycle, the cycle the interrupt redirect issues.
- Reset (incl. mid-WAIT_MEM/IFENCE_WAIT): state RUN, latches cleared; during RST pc_en=0, stall=0, flush all 1, npc_sel=0, redirect_pc=0, iren=0, intr_taken=0, counters 0.

## Configuration
- HAZARD_PERF_COUNTERS_EN: defined → stall_cnt increments each cycle stall[0]=1, flush_cnt each cycle any flush bit set (excluding reset); saturate at max. Undefined → ports absent, no counter logic.

## Structure
- Shared package hazard_pkg: state enum hazard_state_t, redirect source enum redir_src_t, priority constants.
- Sub-module hazard_redirect_arb: combinational priority select of source/target.

## Test plan
- rd_ex=5, load_ex=1, rs1_id=5 → stall[1:0]=11, flush[2]=1, pc_en=0 one cycle; rd_ex=0 → no stall.
- mispredict, brj_addr=0x200, d_mem_busy=0 → npc_sel=1, redirect_pc=0x200, flush=00111.
- jump with d_mem_busy=1 for 3 cycles → WAIT_MEM, all stalled, redirect on cycle 4.
- intr+mispredict same cycle, priv_pc=0x80 → redirect_pc=0x80, flush=01111, intr_taken=1 pulse.
- ifence, ifence_pc=0x44, flush done after 5 cycles → pc_en=0 5 cycles, then redirect 0x44.
- RST asserted in IFENCE_WAIT → flush all 1; next cycle RUN, pc_en=1.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the hazard/redirect controller: FSM states, redirect sources, priority order.
// Purely declarative; no latency or backpressure of its own.
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_WAIT_MEM,
    ST_IFENCE_WAIT,
    ST_HALTED
  } hazard_state_t;

  typedef enum logic [2:0] {
    SRC_NONE,
    SRC_INTR,
    SRC_EXC,
    SRC_RET,
    SRC_BRJ,
    SRC_CSR,
    SRC_IFENCE
  } redir_src_t;

  // Lower index wins.
  localparam int PRIO_INTR   = 0;
  localparam int PRIO_EXC    = 1;
  localparam int PRIO_RET    = 2;
  localparam int PRIO_BRJ    = 3;
  localparam int PRIO_CSR    = 4;
  localparam int PRIO_IFENCE = 5;
  localparam int N_REDIR     = 6;

  function automatic logic is_trap(redir_src_t s);
    return (s == SRC_INTR) || (s == SRC_EXC);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle; master = controller, slave = pipeline side.
// Counter signals exist only with HAZARD_PERF_COUNTERS_EN.
interface pipe_hazard_ctrl_if #(
  parameter int NUM_STAGES = 5
`ifdef HAZARD_PERF_COUNTERS_EN
  , parameter int CNT_W = 32
`endif
);
  logic                  i_mem_busy, d_mem_busy, dren, dwen;
  logic                  load_ex;
  logic [4:0]            rd_ex, rs1_id, rs2_id;
  logic                  mispredict, jump;
  logic [31:0]           brj_addr;
  logic                  csr_flush_req;
  logic [31:0]           csr_pc;
  logic                  ifence;
  logic [31:0]           ifence_pc;
  logic                  dflushed, iflushed;
  logic                  exception, ret, intr;
  logic [31:0]           priv_pc;
  logic                  halt;
  logic                  pc_en;
  logic [NUM_STAGES-1:0] stall;
  logic [NUM_STAGES-1:0] flush;
  logic                  npc_sel;
  logic [31:0]           redirect_pc;
  logic                  iren, dmem_access;
  logic                  intr_taken;
`ifdef HAZARD_PERF_COUNTERS_EN
  logic [CNT_W-1:0]      stall_cnt, flush_cnt;
`endif

  modport master (
    input  i_mem_busy, d_mem_busy, dren, dwen, load_ex, rd_ex, rs1_id, rs2_id,
           mispredict, jump, brj_addr, csr_flush_req, csr_pc, ifence, ifence_pc,
           dflushed, iflushed, exception, ret, intr, priv_pc, halt,
    output pc_en, stall, flush, npc_sel, redirect_pc, iren, dmem_access, intr_taken
`ifdef HAZARD_PERF_COUNTERS_EN
    , output stall_cnt, flush_cnt
`endif
  );

  modport slave (
    output i_mem_busy, d_mem_busy, dren, dwen, load_ex, rd_ex, rs1_id, rs2_id,
           mispredict, jump, brj_addr, csr_flush_req, csr_pc, ifence, ifence_pc,
           dflushed, iflushed, exception, ret, intr, priv_pc, halt,
    input  pc_en, stall, flush, npc_sel, redirect_pc, iren, dmem_access, intr_taken
`ifdef HAZARD_PERF_COUNTERS_EN
    , input stall_cnt, flush_cnt
`endif
  );

endinterface

// File: rtl/pipe_hazard_ctrl_redirect_arb.sv
// Fixed-priority redirect source/target select; purely combinational, zero latency.
// No backpressure: lower-priority requests are simply not selected.
module hazard_redirect_arb
  import hazard_pkg::*;
(
  input  logic       intr,
  input  logic       exception,
  input  logic       ret,
  input  logic       mispredict,
  input  logic       jump,
  input  logic       csr_flush_req,
  input  logic       ifence,
  input  logic [31:0] priv_pc,
  input  logic [31:0] brj_addr,
  input  logic [31:0] csr_pc,
  input  logic [31:0] ifence_pc,
  output redir_src_t src,
  output logic [31:0] target
);

  logic [N_REDIR-1:0] req;

  always_comb begin
    req              = '0;
    req[PRIO_INTR]   = intr;
    req[PRIO_EXC]    = exception;
    req[PRIO_RET]    = ret;
    req[PRIO_BRJ]    = mispredict | jump;
    req[PRIO_CSR]    = csr_flush_req;
    req[PRIO_IFENCE] = ifence;
  end

  always_comb begin
    src    = SRC_NONE;
    target = '0;
    if (req[PRIO_INTR]) begin
      src = SRC_INTR;   target = priv_pc;
    end else if (req[PRIO_EXC]) begin
      src = SRC_EXC;    target = priv_pc;
    end else if (req[PRIO_RET]) begin
      src = SRC_RET;    target = priv_pc;
    end else if (req[PRIO_BRJ]) begin
      src = SRC_BRJ;    target = brj_addr;
    end else if (req[PRIO_CSR]) begin
      src = SRC_CSR;    target = csr_pc;
    end else if (req[PRIO_IFENCE]) begin
      src = SRC_IFENCE; target = ifence_pc;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Per-stage stall/flush + fetch redirect controller; outputs combinational, state on CLK.
// Defers redirects behind busy data accesses and holds for ifence flush; perf counters via HAZARD_PERF_COUNTERS_EN.
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int NUM_STAGES = 5,
  parameter int ID_STAGE   = 1,
  parameter int MEM_STAGE  = 3
`ifdef HAZARD_PERF_COUNTERS_EN
  , parameter int CNT_W    = 32
`endif
) (
  input logic CLK,
  input logic RST,
  pipe_hazard_ctrl_if.master hz
);

  localparam logic [NUM_STAGES-1:0] ALL       = '1;
  localparam logic [NUM_STAGES-1:0] ONE       = {{(NUM_STAGES-1){1'b0}}, 1'b1};
  localparam logic [NUM_STAGES-1:0] TO_ID     = ALL >> (NUM_STAGES - 1 - ID_STAGE);
  localparam logic [NUM_STAGES-1:0] BELOW_ID  = ALL >> (NUM_STAGES - ID_STAGE);
  localparam logic [NUM_STAGES-1:0] TO_MEM    = ALL >> (NUM_STAGES - 1 - MEM_STAGE);
  localparam logic [NUM_STAGES-1:0] BELOW_MEM = ALL >> (NUM_STAGES - MEM_STAGE);
  localparam logic [NUM_STAGES-1:0] ID_BIT    = ONE << ID_STAGE;
  localparam logic [NUM_STAGES-1:0] EX_BIT    = ONE << (ID_STAGE + 1);
  localparam logic [NUM_STAGES-1:0] MEM_BIT   = ONE << MEM_STAGE;
  localparam logic [NUM_STAGES-1:0] POST_MEM  = ONE << (MEM_STAGE + 1);

  hazard_state_t state, state_nxt;
  redir_src_t    lat_src, lat_src_nxt, arb_src, eff_src, iss_src;
  logic [31:0]   lat_pc, lat_pc_nxt, arb_pc, eff_pc, iss_pc;
  logic          do_issue, load_use, dmem_stall, intr_ovr;
  logic [NUM_STAGES-1:0] hold_run, bub_run, stall_o, flush_o;
  logic          pc_en_o, npc_sel_o, iren_o, intr_taken_o;
  logic [31:0]   redirect_pc_o;

  hazard_redirect_arb u_arb (
    .intr(hz.intr), .exception(hz.exception), .ret(hz.ret),
    .mispredict(hz.mispredict), .jump(hz.jump), .csr_flush_req(hz.csr_flush_req),
    .ifence(hz.ifence), .priv_pc(hz.priv_pc), .brj_addr(hz.brj_addr),
    .csr_pc(hz.csr_pc), .ifence_pc(hz.ifence_pc), .src(arb_src), .target(arb_pc)
  );

  assign load_use   = hz.load_ex && (hz.rd_ex != 5'd0) &&
                      ((hz.rd_ex == hz.rs1_id) || (hz.rd_ex == hz.rs2_id));
  assign dmem_stall = hz.d_mem_busy && (hz.dren || hz.dwen);
  // A pending interrupt may displace a deferred non-trap redirect.
  assign intr_ovr   = hz.intr && !is_trap(lat_src);
  assign eff_src    = intr_ovr ? SRC_INTR : lat_src;
  assign eff_pc     = intr_ovr ? hz.priv_pc : lat_pc;

  function automatic logic [NUM_STAGES-1:0] redirect_mask(redir_src_t s);
    return is_trap(s) ? (BELOW_MEM | MEM_BIT) : BELOW_MEM;
  endfunction

  // Stage may not be bubbled while a deeper hazard is holding it.
  always_comb begin
    hold_run = '0;
    bub_run  = '0;
    if (load_use)      begin hold_run |= TO_ID;    bub_run |= EX_BIT;   end
    if (dmem_stall)    begin hold_run |= TO_MEM;   bub_run |= POST_MEM; end
    if (hz.i_mem_busy) begin hold_run |= BELOW_ID; bub_run |= ID_BIT;   end
  end

  always_comb begin
    state_nxt     = state;
    lat_src_nxt   = lat_src;
    lat_pc_nxt    = lat_pc;
    stall_o       = '0;
    flush_o       = '0;
    pc_en_o       = 1'b1;
    npc_sel_o     = 1'b0;
    redirect_pc_o = '0;
    iren_o        = 1'b1;
    intr_taken_o  = 1'b0;
    do_issue      = 1'b0;
    iss_src       = SRC_NONE;
    iss_pc        = '0;

    case (state)
      ST_RUN: begin
        if (arb_src != SRC_NONE) begin
          if (hz.d_mem_busy) begin
            stall_o     = ALL;
            pc_en_o     = 1'b0;
            lat_src_nxt = arb_src;
            lat_pc_nxt  = arb_pc;
            state_nxt   = ST_WAIT_MEM;
          end else begin
            do_issue = 1'b1;
            iss_src  = arb_src;
            iss_pc   = arb_pc;
          end
        end else if (hz.halt) begin
          stall_o   = ALL;
          pc_en_o   = 1'b0;
          state_nxt = ST_HALTED;
        end else begin
          stall_o = hold_run;
          flush_o = bub_run & ~hold_run;
          pc_en_o = ~hold_run[0];
        end
      end
      ST_WAIT_MEM: begin
        if (!hz.d_mem_busy) begin
          do_issue = 1'b1;
          iss_src  = eff_src;
          iss_pc   = eff_pc;
        end else begin
          stall_o     = ALL;
          pc_en_o     = 1'b0;
          lat_src_nxt = eff_src;
          lat_pc_nxt  = eff_pc;
        end
      end
      ST_IFENCE_WAIT: begin
        iren_o = 1'b0;
        if (hz.dflushed && hz.iflushed) begin
          npc_sel_o     = 1'b1;
          redirect_pc_o = lat_pc;
          flush_o       = BELOW_MEM;
          lat_src_nxt   = SRC_NONE;
          lat_pc_nxt    = '0;
          state_nxt     = ST_RUN;
        end else begin
          stall_o = TO_MEM;
          pc_en_o = 1'b0;
        end
      end
      ST_HALTED: begin
        stall_o = ALL;
        pc_en_o = 1'b0;
        iren_o  = 1'b0;
      end
      default: state_nxt = ST_RUN;
    endcase

    if (do_issue) begin
      flush_o = redirect_mask(iss_src);
      if (iss_src == SRC_IFENCE) begin
        // Younger stages are flushed now; the refetch waits for cache flush completion.
        pc_en_o     = 1'b0;
        lat_src_nxt = SRC_IFENCE;
        lat_pc_nxt  = iss_pc;
        state_nxt   = ST_IFENCE_WAIT;
      end else begin
        npc_sel_o     = 1'b1;
        redirect_pc_o = iss_pc;
        intr_taken_o  = (iss_src == SRC_INTR);
        lat_src_nxt   = SRC_NONE;
        lat_pc_nxt    = '0;
        state_nxt     = ST_RUN;
      end
    end

    if (RST) begin
      pc_en_o       = 1'b0;
      stall_o       = '0;
      flush_o       = ALL;
      npc_sel_o     = 1'b0;
      redirect_pc_o = '0;
      iren_o        = 1'b0;
      intr_taken_o  = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= ST_RUN;
      lat_src <= SRC_NONE;
      lat_pc  <= '0;
    end else begin
      state   <= state_nxt;
      lat_src <= lat_src_nxt;
      lat_pc  <= lat_pc_nxt;
    end
  end

  assign hz.pc_en       = pc_en_o;
  assign hz.stall       = stall_o;
  assign hz.flush       = flush_o;
  assign hz.npc_sel     = npc_sel_o;
  assign hz.redirect_pc = redirect_pc_o;
  assign hz.iren        = iren_o;
  assign hz.dmem_access = hz.dren | hz.dwen;
  assign hz.intr_taken  = intr_taken_o;

`ifdef HAZARD_PERF_COUNTERS_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_o[0] && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if ((|flush_o) && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed table + sequence bench for pipe_hazard_ctrl (5 stages, ID=1, MEM=3).
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(
    .NUM_STAGES(5)
`ifdef HAZARD_PERF_COUNTERS_EN
    , .CNT_W(32)
`endif
  ) hz ();

  pipe_hazard_ctrl #(
    .NUM_STAGES(5), .ID_STAGE(1), .MEM_STAGE(3)
`ifdef HAZARD_PERF_COUNTERS_EN
    , .CNT_W(32)
`endif
  ) dut (
    .CLK(clk),
    .RST(rst),
    .hz (hz)
  );

  localparam logic [10:0] F_LD  = 11'h001, F_MIS = 11'h002, F_JMP = 11'h004,
                          F_INT = 11'h008, F_EXC = 11'h010, F_RET = 11'h020,
                          F_CSR = 11'h040, F_IB  = 11'h080, F_DB  = 11'h100,
                          F_DR  = 11'h200, F_DW  = 11'h400;

  typedef struct {
    logic [10:0] flg;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] brj, priv, csrpc;
    logic        pc_en;
    logic [4:0]  stall, flush;
    logic        npc;
    logic [31:0] rpc;
    logic        it;
  } vec_t;

  localparam int NV = 19;
  vec_t tv [NV];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [46:0] obs();
    return {hz.pc_en, hz.stall, hz.flush, hz.npc_sel, hz.redirect_pc,
            hz.iren, hz.dmem_access, hz.intr_taken};
  endfunction

  task automatic idle();
    hz.i_mem_busy = 0; hz.d_mem_busy = 0; hz.dren = 0; hz.dwen = 0;
    hz.load_ex = 0; hz.rd_ex = 0; hz.rs1_id = 0; hz.rs2_id = 0;
    hz.mispredict = 0; hz.jump = 0; hz.brj_addr = 0;
    hz.csr_flush_req = 0; hz.csr_pc = 0; hz.ifence = 0; hz.ifence_pc = 0;
    hz.dflushed = 0; hz.iflushed = 0;
    hz.exception = 0; hz.ret = 0; hz.intr = 0; hz.priv_pc = 0; hz.halt = 0;
  endtask

  task automatic apply(input vec_t v);
    idle();
    hz.load_ex    = v.flg[0];  hz.mispredict    = v.flg[1]; hz.jump      = v.flg[2];
    hz.intr       = v.flg[3];  hz.exception     = v.flg[4]; hz.ret       = v.flg[5];
    hz.csr_flush_req = v.flg[6]; hz.i_mem_busy  = v.flg[7]; hz.d_mem_busy = v.flg[8];
    hz.dren       = v.flg[9];  hz.dwen          = v.flg[10];
    hz.rd_ex = v.rd; hz.rs1_id = v.rs1; hz.rs2_id = v.rs2;
    hz.brj_addr = v.brj; hz.priv_pc = v.priv; hz.csr_pc = v.csrpc;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //         flg            rd    rs1   rs2   brj        priv       csr        pc_en stall     flush     npc  rpc        it
    tv[0]  = '{11'h0,         5'd0, 5'd0, 5'd0, 32'h0,     32'h0,     32'h0,     1'b1, 5'b00000, 5'b00000, 1'b0, 32'h0,     1'b0};
    tv[1]  = '{F_LD,          5'd5, 5'd5, 5'd0, 32'h0,     32'h0,     32'h0,     1'b0, 5'b00011, 5'b00100, 1'b0, 32'h0,     1'b0};
    tv[2]  = '{F_LD,          5'd7, 5'd3, 5'd7, 32'h0,     32'h0,     32'h0,     1'b0, 5'b00011, 5'b00100, 1'b0, 32'h0,     1'b0};
    tv[3]  = '{F_LD,          5'd0, 5'd0, 5'd0, 32'h0,     32'h0,     32'h0,     1'b1, 5'b00000, 5'b00000, 1'b0, 32'h0,     1'b0};
    tv[4]  = '{11'h0,         5'd5, 5'd5, 5'd5, 32'h0,     32'h0,     32'h0,     1'b1, 5'b00000, 5'b00000, 1'b0, 32'h0,     1'b0};
    tv[5]  = '{F_MIS,         5'd0, 5'd0, 5'd0, 32'h200,   32'h0,     32'h0,     1'b1, 5'b00000, 5'b00111, 1'b1, 32'h200,   1'b0};
    tv[6]  = '{F_JMP|F_CSR,   5'd0, 5'd0, 5'd0, 32'h300,   32'h0,     32'h120,   1'b1, 5'b00000, 5'b00111, 1'b1, 32'h300,   1'b0};
    tv[7]  = '{F_INT|F_MIS,   5'd0, 5'd0, 5'd0, 32'h200,   32'h80,    32'h0,     1'b1, 5'b00000, 5'b01111, 1'b1, 32'h80,    1'b1};
    tv[8]  = '{F_EXC|F_RET,   5'd0, 5'd0, 5'd0, 32'h0,     32'h90,    32'h0,     1'b1, 5'b00000, 5'b01111, 1'b1, 32'h90,    1'b0};
    tv[9]  = '{F_RET,         5'd0, 5'd0, 5'd0, 32'h0,     32'hA0,    32'h0,     1'b1, 5'b00000, 5'b00111, 1'b1, 32'hA0,    1'b0};
    tv[10] = '{F_CSR,         5'd0, 5'd0, 5'd0, 32'h0,     32'h0,     32'h120,   1'b1, 5'b00000, 5'b00111, 1'b1, 32'h120,   1'b0};
    tv[11] = '{F_MIS|F_LD,    5'd5, 5'd5, 5'd0, 32'h240,   32'h0,     32'h0,     1'b1, 5'b00000, 5'b00111, 1'b1, 32'h240,   1'b0};
    tv[12] = '{F_IB,          5'd0, 5'd0, 5'd0, 32'h0,     32'h0,     32'h0,     1'b0, 5'b00001, 5'b00010, 1'b0, 32'h0,     1'b0};
    tv[13] = '{F_IB|F_LD,     5'd5, 5'd5, 5'd0, 32'h0,     32'h0,     32'h0,     1'b0, 5'b00011, 5'b00100, 1'b0, 32'h0,     1'b0};
    tv[14] = '{F_DB|F_DR,     5'd0, 5'd0, 5'd0, 32'h0,     32'h0,     32'h0,     1'b0, 5'b01111, 5'b10000, 1'b0, 32'h0,     1'b0};
    tv[15] = '{F_DB|F_DW,     5'd0, 5'd0, 5'd0, 32'h0,     32'h0,     32'h0,     1'b0, 5'b01111, 5'b10000, 1'b0, 32'h0,     1'b0};
    tv[16] = '{F_DB,          5'd0, 5'd0, 5'd0, 32'h0,     32'h0,     32'h0,     1'b1, 5'b00000, 5'b00000, 1'b0, 32'h0,     1'b0};
    tv[17] = '{F_IB|F_DB|F_DR,5'd0, 5'd0, 5'd0, 32'h0,     32'h0,     32'h0,     1'b0, 5'b01111, 5'b10000, 1'b0, 32'h0,     1'b0};
    tv[18] = '{F_MIS|F_IB,    5'd0, 5'd0, 5'd0, 32'h260,   32'h0,     32'h0,     1'b1, 5'b00000, 5'b00111, 1'b1, 32'h260,   1'b0};

    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", obs(), {1'b0, 5'b00000, 5'b11111, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0});
    next_cycle();
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      next_cycle();
      apply(tv[i]);
      @(negedge clk);
      check($sformatf("vec%0d", i), obs(),
            {tv[i].pc_en, tv[i].stall, tv[i].flush, tv[i].npc, tv[i].rpc,
             1'b1, tv[i].flg[9] | tv[i].flg[10], tv[i].it});
    end

    // Jump deferred behind a busy data access for three cycles.
    next_cycle(); idle();
    hz.jump = 1; hz.brj_addr = 32'h300; hz.d_mem_busy = 1;
    @(negedge clk);
    check("wm_enter_stall", hz.stall, 5'b11111);
    check("wm_enter_npc", {hz.npc_sel, hz.pc_en}, 2'b00);
    for (int c = 2; c <= 3; c++) begin
      next_cycle(); idle();
      hz.d_mem_busy = 1; hz.mispredict = 1; hz.brj_addr = 32'h999;
      @(negedge clk);
      check($sformatf("wm_hold%0d", c), {hz.stall, hz.npc_sel, hz.pc_en}, {5'b11111, 2'b00});
    end
    next_cycle(); idle();
    @(negedge clk);
    check("wm_exit", {hz.npc_sel, hz.redirect_pc, hz.flush, hz.stall},
          {1'b1, 32'h300, 5'b00111, 5'b00000});
    next_cycle();
    @(negedge clk);
    check("wm_after", {hz.npc_sel, hz.pc_en, hz.stall}, {1'b0, 1'b1, 5'b00000});

    // Interrupt arriving while a branch redirect is deferred takes its place.
    next_cycle(); idle();
    hz.mispredict = 1; hz.brj_addr = 32'h500; hz.d_mem_busy = 1;
    next_cycle(); idle();
    hz.intr = 1; hz.priv_pc = 32'h80; hz.d_mem_busy = 1;
    @(negedge clk);
    check("wm_intr_hold", {hz.intr_taken, hz.npc_sel, hz.stall}, {2'b00, 5'b11111});
    next_cycle(); idle();
    @(negedge clk);
    check("wm_intr_issue", {hz.npc_sel, hz.redirect_pc, hz.flush, hz.intr_taken},
          {1'b1, 32'h80, 5'b01111, 1'b1});
    next_cycle();
    @(negedge clk);
    check("wm_intr_pulse_end", {hz.intr_taken, hz.npc_sel}, 2'b00);

    // ifence: flush now, hold until both caches report flushed on the fifth cycle.
    next_cycle(); idle();
    hz.ifence = 1; hz.ifence_pc = 32'h44;
    @(negedge clk);
    check("if_enter", {hz.flush, hz.pc_en, hz.npc_sel, hz.stall},
          {5'b00111, 1'b0, 1'b0, 5'b00000});
    for (int c = 1; c <= 4; c++) begin
      next_cycle(); idle();
      hz.ifence_pc = 32'h44;
      hz.dflushed = (c == 4);
      @(negedge clk);
      check($sformatf("if_wait%0d", c), {hz.pc_en, hz.stall, hz.iren, hz.npc_sel},
            {1'b0, 5'b01111, 1'b0, 1'b0});
    end
    next_cycle(); idle();
    hz.ifence_pc = 32'h44; hz.dflushed = 1; hz.iflushed = 1;
    @(negedge clk);
    check("if_exit", {hz.npc_sel, hz.redirect_pc, hz.pc_en}, {1'b1, 32'h44, 1'b1});
    next_cycle(); idle();
    @(negedge clk);
    check("if_after", {hz.iren, hz.npc_sel, hz.pc_en}, 3'b101);

    // Reset while waiting on ifence.
    next_cycle(); idle();
    hz.ifence = 1; hz.ifence_pc = 32'h44;
    next_cycle(); idle();
    rst = 1'b1;
    @(negedge clk);
    check("if_rst", {hz.flush, hz.pc_en, hz.iren, hz.stall}, {5'b11111, 1'b0, 1'b0, 5'b00000});
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("if_rst_run", {hz.pc_en, hz.stall, hz.iren, hz.flush}, {1'b1, 5'b00000, 1'b1, 5'b00000});

    // Halt: frozen until reset, later redirects ignored.
    next_cycle(); idle();
    hz.halt = 1;
    @(negedge clk);
    check("halt_enter", {hz.pc_en, hz.stall}, {1'b0, 5'b11111});
    next_cycle(); idle();
    hz.mispredict = 1; hz.brj_addr = 32'h700;
    @(negedge clk);
    check("halt_hold", {hz.npc_sel, hz.iren, hz.pc_en, hz.stall}, {3'b000, 5'b11111});
    next_cycle();
    @(negedge clk);
    check("halt_hold2", {hz.iren, hz.pc_en}, 2'b00);
    next_cycle(); idle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("halt_rst_run", {hz.pc_en, hz.iren, hz.stall}, {2'b11, 5'b00000});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
